// File: rtl/front_panel_ctrl.sv
// front_panel_ctrl: operator front panel that turns raw run/clear/mode/step
// switches into a processor clock enable, a PC reset and panel lamps.
module front_panel_ctrl #(
  parameter int unsigned DEB_LEN = 8,
  parameter int unsigned CLR_LEN = 4,
  parameter int unsigned STEP_N  = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             RST_N,
  input  logic             RUN,
  input  logic             CLR,
  input  logic             A_M,
  input  logic             MAN_CLK,
  input  logic             HALT_REQ,
  output logic             CLK_EN,
  output logic             PC_RST,
  output logic             RUN_ind,
  output logic             CLR_ind,
  output logic             A_M_ind,
  output logic [CNT_W-1:0] STEP_CNT
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_AUTO   = 3'd1;
  localparam logic [2:0] S_MANUAL = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;

  localparam logic [7:0] DEB_LAST  = 8'(DEB_LEN - 1);
  localparam logic [7:0] CLR_LAST  = 8'(CLR_LEN - 1);
  localparam logic [7:0] STEP_LAST = 8'(STEP_N - 1);

  // bit positions of the panel inputs in the synchroniser/debounce vectors
  localparam int unsigned I_RUN = 0;
  localparam int unsigned I_CLR = 1;
  localparam int unsigned I_AM  = 2;
  localparam int unsigned I_MAN = 3;

  logic [3:0]      raw_in;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      deb;
  logic [3:0][7:0] deb_cnt;
  logic            clr_d;
  logic            man_d;
  logic            clr_rise;
  logic            step_rise;
  logic            go_idle;
  logic [2:0]      state;
  logic [2:0]      next_state;
  logic [7:0]      phase_cnt;

  assign raw_in = {MAN_CLK, A_M, CLR, RUN};

  // two-flop synchronisers for the asynchronous panel inputs
  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // debouncers: flip only after DEB_LEN consecutive differing samples
  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      deb     <= '0;
      deb_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // edge-detect history for the clear and step buttons
  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      clr_d <= 1'b0;
      man_d <= 1'b0;
    end else begin
      clr_d <= deb[I_CLR];
      man_d <= deb[I_MAN];
    end
  end

  assign clr_rise  = deb[I_CLR] & ~clr_d;
  assign step_rise = deb[I_MAN] & ~man_d;
  assign go_idle   = ~deb[I_RUN] | HALT_REQ;

  // next-state logic; a clear press overrides everything
  always_comb begin
    next_state = state;
    if (clr_rise) begin
      next_state = S_CLEAR;
    end else begin
      case (state)
        S_IDLE: begin
          if (!go_idle) next_state = deb[I_AM] ? S_MANUAL : S_AUTO;
        end
        S_AUTO: begin
          if (go_idle)        next_state = S_IDLE;
          else if (deb[I_AM]) next_state = S_MANUAL;
        end
        S_MANUAL: begin
          if (go_idle)         next_state = S_IDLE;
          else if (!deb[I_AM]) next_state = S_AUTO;
          else if (step_rise)  next_state = S_STEP;
        end
        S_STEP: begin
          // exit follows the manual rules; a step press seen while stepping
          // is dropped rather than chaining another step
          if (phase_cnt == STEP_LAST) begin
            if (go_idle)        next_state = S_IDLE;
            else if (deb[I_AM]) next_state = S_MANUAL;
            else                next_state = S_AUTO;
          end
        end
        S_CLEAR: begin
          if (phase_cnt >= CLR_LAST && !deb[I_CLR]) next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= next_state;
  end

  // cycles spent in the current state, restarted on every entry
  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      phase_cnt <= '0;
    end else if (next_state != state || clr_rise) begin
      phase_cnt <= '0;
    end else if (phase_cnt != 8'hFF) begin
      phase_cnt <= phase_cnt + 8'd1;
    end
  end

  // registered outputs decoded from the next state so they align with state
  always_ff @(posedge clock or negedge RST_N) begin
    if (!RST_N) begin
      CLK_EN   <= 1'b0;
      PC_RST   <= 1'b0;
      STEP_CNT <= '0;
    end else begin
      CLK_EN <= (next_state == S_AUTO) || (next_state == S_STEP);
      PC_RST <= (next_state == S_CLEAR);
      if (next_state == S_CLEAR) STEP_CNT <= '0;
      else if (CLK_EN)           STEP_CNT <= STEP_CNT + CNT_W'(1);
    end
  end

  assign RUN_ind = (state == S_AUTO) || (state == S_MANUAL) || (state == S_STEP);
  assign CLR_ind = PC_RST;
  assign A_M_ind = ~deb[I_AM];

endmodule

// File: tb/tb_front_panel_ctrl.sv
// tb_front_panel_ctrl: directed scenarios for front_panel_ctrl, checked every
// cycle against a timestamp-based behavioural model plus literal expectations.
module tb_front_panel_ctrl;

  localparam int DEB_LEN = 8;
  localparam int CLR_LEN = 4;
  localparam int STEP_N  = 3;
  localparam int CNT_W   = 4;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic run      = 1'b0;
  logic clr      = 1'b0;
  logic a_m      = 1'b0;
  logic man_clk  = 1'b0;
  logic halt_req = 1'b0;
  logic clk_en;
  logic pc_rst;
  logic run_ind;
  logic clr_ind;
  logic a_m_ind;
  logic [CNT_W-1:0] step_cnt;

  int checks  = 0;
  int errors  = 0;
  int en_seen = 0;

  always #5 clk = ~clk;

  front_panel_ctrl #(
    .DEB_LEN(DEB_LEN),
    .CLR_LEN(CLR_LEN),
    .STEP_N (STEP_N),
    .CNT_W  (CNT_W)
  ) dut (
    .clock   (clk),
    .RST_N   (rst_n),
    .RUN     (run),
    .CLR     (clr),
    .A_M     (a_m),
    .MAN_CLK (man_clk),
    .HALT_REQ(halt_req),
    .CLK_EN  (clk_en),
    .PC_RST  (pc_rst),
    .RUN_ind (run_ind),
    .CLR_ind (clr_ind),
    .A_M_ind (a_m_ind),
    .STEP_CNT(step_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_AUTO, M_MAN, M_STEP, M_CLR} mstate_t;

  mstate_t m_st    = M_IDLE;
  int      m_n     = 0;   // edges since reset released
  int      m_t     = 0;   // edge at which STEP/CLEAR was entered
  int      m_total = 0;   // CLK_EN cycles since last clear
  bit      m_deb  [4];
  bit      m_prev [4];
  bit      hist   [4][0:8191];

  // raw input sampled at edge idx; before reset release everything reads 0
  function automatic bit raw_at(input int k, input int idx);
    if (idx <= 0) return 1'b0;
    return hist[k][idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit clr_r;
    bit step_r;
    bit must_idle;
    bit flip;
    if (!rst_n) begin
      m_st    = M_IDLE;
      m_n     = 0;
      m_t     = 0;
      m_total = 0;
      for (int k = 0; k < 4; k++) begin
        m_deb[k]  = 1'b0;
        m_prev[k] = 1'b0;
      end
    end else begin
      m_n++;
      hist[0][m_n] = run;
      hist[1][m_n] = clr;
      hist[2][m_n] = a_m;
      hist[3][m_n] = man_clk;
      clr_r     = m_deb[1] && !m_prev[1];
      step_r    = m_deb[3] && !m_prev[3];
      must_idle = !m_deb[0] || halt_req;
      if (m_st == M_AUTO || m_st == M_STEP) m_total++;
      if (clr_r) begin
        m_st = M_CLR;
        m_t  = m_n;
      end else begin
        case (m_st)
          M_IDLE: if (!must_idle) m_st = m_deb[2] ? M_MAN : M_AUTO;
          M_AUTO: if (must_idle) m_st = M_IDLE; else if (m_deb[2]) m_st = M_MAN;
          M_MAN: begin
            if (must_idle)      m_st = M_IDLE;
            else if (!m_deb[2]) m_st = M_AUTO;
            else if (step_r) begin
              m_st = M_STEP;
              m_t  = m_n;
            end
          end
          M_STEP: if (m_n - m_t == STEP_N)
                    m_st = must_idle ? M_IDLE : (m_deb[2] ? M_MAN : M_AUTO);
          M_CLR:  if (m_n - m_t >= CLR_LEN && !m_deb[1]) m_st = M_IDLE;
          default: m_st = M_IDLE;
        endcase
      end
      if (m_st == M_CLR) m_total = 0;
      // debounced value flips once the last DEB_LEN synchronised samples
      // (raw delayed by two edges) all disagree with it
      for (int k = 0; k < 4; k++) begin
        flip = 1'b1;
        for (int j = m_n - 1 - DEB_LEN; j <= m_n - 2; j++)
          if (raw_at(k, j) == m_deb[k]) flip = 1'b0;
        m_prev[k] = m_deb[k];
        if (flip) m_deb[k] = !m_deb[k];
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    check("CLK_EN",   clk_en,   int'(m_st == M_AUTO || m_st == M_STEP));
    check("PC_RST",   pc_rst,   int'(m_st == M_CLR));
    check("RUN_ind",  run_ind,  int'(m_st == M_AUTO || m_st == M_MAN || m_st == M_STEP));
    check("CLR_ind",  clr_ind,  int'(m_st == M_CLR));
    check("A_M_ind",  a_m_ind,  int'(!m_deb[2]));
    check("STEP_CNT", step_cnt, m_total % (1 << CNT_W));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (clk_en) en_seen++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " CLK_EN"},   clk_en,   0);
    check({tag, " PC_RST"},   pc_rst,   0);
    check({tag, " RUN_ind"},  run_ind,  0);
    check({tag, " CLR_ind"},  clr_ind,  0);
    check({tag, " A_M_ind"},  a_m_ind,  1);
    check({tag, " STEP_CNT"}, step_cnt, 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int e0;
    int hi;

    // reset values
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    // auto run: debounce 10 edges, state one edge later
    run = 1'b1;
    tick(10);
    check("auto before rise", clk_en, 0);
    tick(1);
    check("auto rise", clk_en, 1);
    tick(5);
    check("auto cnt 5", step_cnt, 5);
    tick(10);
    check("auto cnt 15", step_cnt, 15);
    tick(1);
    check("auto wrap 0", step_cnt, 0);
    tick(1);
    check("auto wrap 1", step_cnt, 1);

    // halt request in auto
    halt_req = 1'b1;
    tick(1);
    check("halt CLK_EN", clk_en, 0);
    check("halt RUN_ind", run_ind, 0);
    tick(3);
    halt_req = 1'b0;
    tick(1);
    check("resume CLK_EN", clk_en, 1);
    check("resume STEP_CNT", step_cnt, 2);

    // step press in auto is discarded
    man_clk = 1'b1;
    tick(15);
    man_clk = 1'b0;
    tick(15);
    a_m = 1'b1;
    tick(11);
    check("manual CLK_EN", clk_en, 0);
    check("manual RUN_ind", run_ind, 1);
    check("manual A_M_ind", a_m_ind, 0);
    e0 = en_seen;
    tick(10);
    check("no queued step", en_seen - e0, 0);

    // clean manual step
    e0 = en_seen;
    man_clk = 1'b1;
    tick(25);
    man_clk = 1'b0;
    tick(25);
    check("clean step pulses", en_seen - e0, STEP_N);

    // bouncing step button, then stable
    e0 = en_seen;
    for (int i = 0; i < 40; i++) begin
      man_clk = (i % 3 != 2);
      tick(1);
    end
    man_clk = 1'b1;
    tick(25);
    man_clk = 1'b0;
    tick(25);
    check("bounce step pulses", en_seen - e0, STEP_N);

    // clear pressed during a step
    man_clk = 1'b1;
    tick(1);
    clr = 1'b1;
    tick(10);
    check("in step CLK_EN", clk_en, 1);
    tick(1);
    check("clear CLK_EN", clk_en, 0);
    check("clear PC_RST", pc_rst, 1);
    check("clear STEP_CNT", step_cnt, 0);
    tick(1);
    clr = 1'b0;
    hi = 0;
    while (hi < 40) begin
      tick(1);
      if (!pc_rst) break;
      hi++;
    end
    check("clear hold cycles", hi, 10);
    check("after clear RUN_ind", run_ind, 0);
    man_clk = 1'b0;
    tick(15);

    // reset asserted mid-step
    man_clk = 1'b1;
    tick(11);
    check("step before reset", clk_en, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("step reset");
    e0 = en_seen;
    tick(4);
    check("no pulse in reset", en_seen - e0, 0);
    rst_n   = 1'b1;
    man_clk = 1'b0;
    a_m     = 1'b0;
    tick(20);
    check("auto after reset", clk_en, 1);

    // reset asserted mid auto run
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("run reset");
    tick(2);
    rst_n = 1'b1;
    tick(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/front_panel_ctrl.md
FRONT_PANEL_CTRL -- requirements
Module: front_panel_ctrl

Interface
REQ-001 Parameter DEB_LEN, default 8: consecutive stable cycles required before a debounced input changes (range 2..255).
REQ-002 Parameter CLR_LEN, default 4: minimum cycles PC_RST is held asserted (range 1..255).
REQ-003 Parameter STEP_N, default 1: CLK_EN pulses issued per manual step (range 1..255).
REQ-004 Parameter CNT_W, default 16: width of STEP_CNT.
REQ-005 Port list SHALL be, clock and reset first:
- clock  in  1  single system clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RUN  in  1  raw run switch; 1 = run.
- CLR  in  1  raw clear pushbutton; 1 = pressed.
- A_M  in  1  raw mode switch; 0 = auto, 1 = manual.
- MAN_CLK  in  1  raw manual-step pushbutton.
- HALT_REQ  in  1  synchronous halt request from the processor, already in the clock domain.
- CLK_EN  out  1  processor clock enable; the processor clock is never muxed or gated.
- PC_RST  out  1  processor/PC reset.
- RUN_ind  out  1  run lamp.
- CLR_ind  out  1  clear lamp.
- A_M_ind  out  1  mode lamp; 1 = auto.
- STEP_CNT  out  CNT_W  count of issued CLK_EN cycles.

Function
REQ-006 RUN, CLR, A_M and MAN_CLK SHALL each pass through a two-flop synchroniser.
REQ-007 Each debouncer SHALL change its output only after the synchronised input differs from it for DEB_LEN consecutive cycles; any return to the current value restarts the count.
REQ-008 Raw input change to debounced change SHALL take exactly 2+DEB_LEN cycles when the input is clean.
REQ-009 Rising-edge detectors SHALL produce one-cycle pulses from debounced CLR (clr_rise) and debounced MAN_CLK (step_rise).
REQ-010 The FSM SHALL have exactly five states: IDLE, AUTO, MANUAL, STEP, CLEAR.
REQ-011 clr_rise SHALL force CLEAR from any state, with priority over every other transition.
REQ-012 CLEAR: PC_RST=1 and CLK_EN=0; the FSM SHALL exit to IDLE only after at least CLR_LEN cycles in CLEAR and with debounced CLR low.
REQ-013 IDLE: if debounced RUN=1 and HALT_REQ=0, the FSM SHALL go to AUTO when debounced A_M=0, else to MANUAL.
REQ-014 AUTO: the FSM SHALL go to IDLE if RUN=0 or HALT_REQ=1, else to MANUAL if A_M=1.
REQ-015 MANUAL: the FSM SHALL go to IDLE if RUN=0 or HALT_REQ=1; else to AUTO if A_M=0; else to STEP on step_rise.
REQ-016 STEP SHALL last exactly STEP_N cycles; only CLEAR may interrupt it; RUN, A_M and HALT_REQ changes during STEP take effect on exit.
REQ-017 STEP exit SHALL follow the MANUAL rules of REQ-015, evaluated on the last STEP cycle.
REQ-018 step_rise outside MANUAL SHALL be discarded, never queued.
REQ-019 CLK_EN SHALL be Moore and registered: 1 exactly when state is AUTO or STEP.
REQ-020 STEP_CNT SHALL increment by 1 each cycle CLK_EN=1, wrap from all-ones to 0, and clear to 0 while in CLEAR.
REQ-021 RUN_ind SHALL be 1 in AUTO, MANUAL and STEP.
REQ-022 CLR_ind SHALL equal PC_RST.
REQ-023 A_M_ind SHALL equal the inverse of debounced A_M.

Reset
REQ-024 RST_N=0 SHALL asynchronously force state IDLE, all synchroniser, debounce and edge flops to 0, and all counters to 0.
REQ-025 During and after reset, until inputs change, outputs SHALL be CLK_EN=0, PC_RST=0, RUN_ind=0, CLR_ind=0, A_M_ind=1, STEP_CNT=0.
REQ-026 RST_N asserted mid-STEP or mid-CLEAR SHALL abort immediately with no further CLK_EN pulse.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- RUN=1, A_M=0, clean -> CLK_EN rises 11 cycles after RUN (DEB_LEN=8) plus one state cycle; STEP_CNT increments each cycle.
- Manual, STEP_N=3, one clean MAN_CLK press -> exactly 3 CLK_EN cycles, STEP_CNT +3; press while in AUTO -> no extra pulses.
- MAN_CLK bouncing at 3-cycle period for 40 cycles, then stable high -> exactly one step.
- CLR pressed mid-STEP for 2 cycles after debounce -> CLK_EN=0 next cycle, PC_RST high >= CLR_LEN cycles and until CLR released, STEP_CNT=0, then IDLE.
- HALT_REQ=1 during AUTO -> CLK_EN=0 next cycle, RUN_ind=0; HALT_REQ=0 with RUN=1 -> AUTO resumes.
- CNT_W=4, 17 auto cycles -> STEP_CNT wraps 15 -> 0 -> 1; RST_N pulsed low mid-run -> all outputs to REQ-025 values immediately.
